// File: rtl/mem_copy_master_pkg.sv
// Shared definitions for the memory-port masters: FSM state encodings and RW codes.
package mem_copy_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/mem_copy_master_if.sv
// Control handshake plus Vr_data_mem port (ADDR/RW/WD/RD) of the copy master.
interface mem_copy_master_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int LW = 16
) ();
  logic          start;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [LW-1:0] count;
  logic [DW-1:0] checksum;
  logic [AW-1:0] addr;
  logic          rw;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd;

  modport master (
    input  start, src, dst, len, rd,
    output busy, done, count, checksum, addr, rw, wd
  );

  modport slave (
    output start, src, dst, len, rd,
    input  busy, done, count, checksum, addr, rw, wd
  );
endinterface

// File: rtl/mem_copy_master_addr_gen.sv
// Source/destination pointer pair: loaded once per copy, then stepped up or down together.
module mem_addr_gen #(
  parameter int AW        = 32,
  parameter int ADDR_STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          dn_i,
  input  logic          step_i,
  input  logic [AW-1:0] s_init_i,
  input  logic [AW-1:0] d_init_i,
  output logic [AW-1:0] s_o,
  output logic [AW-1:0] d_o
);
  localparam logic [AW-1:0] STEP = AW'(ADDR_STEP);

  logic [AW-1:0] s_q, s_d, d_q, d_d;
  logic          dn_q, dn_d;

  // Load wins over step; arithmetic wraps naturally at AW bits.
  always_comb begin
    s_d  = s_q;
    d_d  = d_q;
    dn_d = dn_q;
    if (load_i) begin
      s_d  = s_init_i;
      d_d  = d_init_i;
      dn_d = dn_i;
    end else if (step_i) begin
      s_d = dn_q ? s_q - STEP : s_q + STEP;
      d_d = dn_q ? d_q - STEP : d_q + STEP;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q  <= '0;
      d_q  <= '0;
      dn_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      d_q  <= d_d;
      dn_q <= dn_d;
    end
  end

  assign s_o = s_q;
  assign d_o = d_q;
endmodule

// File: rtl/mem_copy_master.sv
// Memmove-safe word copier driving Vr_data_mem with read-then-write cycles and a running checksum.
module mem_copy_master
  import mem_copy_master_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int LW        = 16,
  parameter int ADDR_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_copy_master_if.master  bus
);
  state_e        state_q, state_d;
  logic [AW-1:0] src_q, dst_q;
  logic [LW-1:0] len_q, count_q;
  logic [DW-1:0] buf_q, csum_q;
  logic [AW-1:0] s_ptr, d_ptr, s_init, d_init, ofs;
  logic [AW:0]   src_end;
  logic          bwd;

  // Overlap test at AW+1 bits so a region running past 2^AW still counts as overlapping.
  assign src_end = {1'b0, src_q} + ((AW+1)'(len_q) * (AW+1)'(ADDR_STEP));
  assign bwd     = (dst_q > src_q) && ({1'b0, dst_q} < src_end);
  assign ofs     = AW'(len_q - LW'(1)) * AW'(ADDR_STEP);
  assign s_init  = bwd ? src_q + ofs : src_q;
  assign d_init  = bwd ? dst_q + ofs : dst_q;

  mem_addr_gen #(.AW(AW), .ADDR_STEP(ADDR_STEP)) u_agen (
    .clk      (clk),
    .rst      (rst),
    .load_i   (state_q == ST_SETUP),
    .dn_i     (bwd),
    .step_i   (state_q == ST_WRITE),
    .s_init_i (s_init),
    .d_init_i (d_init),
    .s_o      (s_ptr),
    .d_o      (d_ptr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; START only matters in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_SETUP;
      ST_SETUP: state_d = (len_q == '0) ? ST_FIN : ST_READ;
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: state_d = (count_q + LW'(1) == len_q) ? ST_FIN : ST_READ;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory port and status decoded from state and registers only.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.rw   = RW_READ;
    bus.addr = '0;
    bus.wd   = '0;
    case (state_q)
      ST_SETUP: bus.busy = 1'b1;
      ST_READ: begin
        bus.busy = 1'b1;
        bus.addr = s_ptr;
      end
      ST_WRITE: begin
        bus.busy = 1'b1;
        bus.rw   = RW_WRITE;
        bus.addr = d_ptr;
        bus.wd   = buf_q;
      end
      ST_FIN:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Request capture, read buffer, word count and checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      buf_q   <= '0;
      count_q <= '0;
      csum_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) begin
          src_q   <= bus.src;
          dst_q   <= bus.dst;
          len_q   <= bus.len;
          count_q <= '0;
          csum_q  <= '0;
        end
        ST_READ:  buf_q <= bus.rd;
        ST_WRITE: begin
          count_q <= count_q + LW'(1);
          csum_q  <= csum_q + buf_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.count    = count_q;
  assign bus.checksum = csum_q;
endmodule
